// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional feature: define UART_TX_PARITY_EN to build 8E1 frames (default 8N1).
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be transmitted.
// Depth must be a power of two so the pointers wrap for free.
module uart_tx_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards the contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: FIFO-fed serialiser producing 8N1 frames, or 8E1 frames
// when UART_TX_PARITY_EN is defined.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en_i,
  input  logic [DIV_WIDTH-1:0]          cfg_div_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          tx_done_o
);

  uart_tx_state_e state_q, state_d;
  logic [DIV_WIDTH-1:0]      div_q, div_d;
  logic [DIV_WIDTH-1:0]      cnt_q, cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                idx_q, idx_d;
  logic                      tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      bit_end, start_frame;

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid_i),
    .wdata_i (tx_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign bit_end    = (cnt_q == '0);
  assign tx_ready_o = ~fifo_full;
  assign busy_o     = (state_q != StIdle);
  assign tx_done_o  = (state_q == StStop) && bit_end;
  assign tx_o       = tx_q;

  // Frame sequencing, bit timer and shift register next-state.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (state_q != StIdle) cnt_d = bit_end ? div_q : cnt_q - DIV_WIDTH'(1);

    case (state_q)
      StIdle: begin
        if (cfg_en_i && !fifo_empty) start_frame = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = 3'd0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          // Chain straight into the next frame when more data is queued.
          if (cfg_en_i && !fifo_empty) start_frame = 1'b1;
          else                         state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      div_d    = cfg_div_i;
      cnt_d    = cfg_div_i;
      state_d  = StStart;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_rdata;
`endif
    end
  end

  // Line level for the upcoming cycle, registered so tx_o is glitch-free.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = UART_IDLE_LEVEL;
    endcase
  end

  // State registers; reset forces the line back to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      div_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: a frame-level timeline model predicts
// every output each cycle from the queued bytes and the latched divisor.
module tb_uart_tx_core;

  localparam int DW = 16;
  localparam int FD = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_en = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic [7:0]    tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready_o, tx_o, busy_o, tx_done_o;
  logic [$clog2(FD):0] fifo_level_o;

  uart_tx_core #(
    .DIV_WIDTH  (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_en_i     (cfg_en),
    .cfg_div_i    (cfg_div),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .fifo_level_o (fifo_level_o),
    .tx_done_o    (tx_done_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of accepted bytes plus the frame currently on the line.
  byte unsigned    q[$];
  bit              m_active = 1'b0;
  int              m_t = 0;
  int              m_div = 0;
  logic [NB-1:0]   fbits = '1;

  function automatic logic exp_tx();
    return m_active ? fbits[m_t / (m_div + 1)] : 1'b1;
  endfunction

  function automatic logic exp_done();
    return m_active && (m_t == NB * (m_div + 1) - 1);
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit          last;
    bit          push;
    bit          pop;
    byte unsigned b;
    last = exp_done();
    push = tx_valid && (q.size() < FD);
    pop  = cfg_en && (q.size() > 0) && (!m_active || last);
    if (pop) begin
      b = q.pop_front();
      fbits[0] = 1'b0;
      for (int i = 0; i < 8; i++) fbits[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
      fbits[9] = ^b;
`endif
      fbits[NB-1] = 1'b1;
      m_div = int'(cfg_div);
      m_t = 0;
      m_active = 1'b1;
    end else if (m_active) begin
      if (last) m_active = 1'b0;
      else      m_t++;
    end
    if (push) q.push_back(tx_data);
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_t = 0;
  endtask

  task automatic check_outputs();
    check_eq("tx", tx_o, exp_tx());
    check_eq("busy", busy_o, m_active);
    check_eq("done", tx_done_o, exp_done());
    check_eq("level", fifo_level_o, q.size());
    check_eq("ready", tx_ready_o, q.size() < FD);
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input byte unsigned b);
    tx_data = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((m_active || q.size() > 0) && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    check_eq("drain_idle", busy_o, 1'b0);
  endtask

  initial begin
    // Reset state, sampled while reset is held.
    repeat (2) @(negedge clk);
    check_eq("rst_tx", tx_o, 1'b1);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_done", tx_done_o, 1'b0);
    check_eq("rst_ready", tx_ready_o, 1'b1);
    check_eq("rst_level", fifo_level_o, 0);
    rst_n = 1'b1;
    tick();

    // Single byte, 10-cycle bits.
    cfg_en = 1'b1;
    cfg_div = 16'd9;
    send(8'h55);
    check_eq("lat_busy", busy_o, 1'b0);
    tick();
    check_eq("lat_start", tx_o, 1'b0);
    drain(200);

    // Divisor 0 gives 1-cycle bits.
    cfg_div = 16'd0;
    send(8'hF0);
    drain(50);

    // Back-to-back frames at the 115200-baud divisor.
    cfg_div = 16'd433;
    send(8'h41);
    send(8'h42);
    send(8'h0A);
    drain(NB * 434 * 3 + 20);

    // Parity-relevant bytes (odd and even number of ones).
    cfg_div = 16'd2;
    send(8'h07);
    send(8'h03);
    drain(100);

    // Fill the FIFO while disabled; ninth offer must be refused.
    cfg_en = 1'b0;
    cfg_div = 16'd1;
    for (int i = 0; i < 9; i++) send(byte'(8'h10 + i));
    check_eq("full_ready", tx_ready_o, 1'b0);
    check_eq("full_level", fifo_level_o, FD);
    cfg_en = 1'b1;
    tick();
    tick();
    check_eq("ready_after_pop", tx_ready_o, 1'b1);
    drain(FD * NB * 2 + 20);

    // Divisor changed mid-frame only affects the next frame.
    cfg_div = 16'd9;
    send(8'hA5);
    send(8'h3C);
    repeat (45) tick();
    cfg_div = 16'd4;
    drain(400);

    // Disable mid-frame: current frame finishes, the queued one waits.
    cfg_div = 16'd3;
    send(8'h96);
    send(8'h69);
    repeat (10) tick();
    cfg_en = 1'b0;
    repeat (60) tick();
    check_eq("en_hold_level", fifo_level_o, 1);
    cfg_en = 1'b1;
    drain(200);

    // Asynchronous reset during DATA.
    cfg_div = 16'd9;
    send(8'h00);
    send(8'hFF);
    repeat (30) tick();
    check_eq("pre_rst_tx", tx_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", tx_o, 1'b1);
    check_eq("mid_rst_level", fifo_level_o, 0);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    tick();

    // Randomised traffic with small divisors.
    for (int c = 0; c < 3000; c++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data = 8'($urandom);
      cfg_en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 63) == 0) cfg_div = DW'($urandom_range(0, 3));
      tick();
    end
    tx_valid = 1'b0;
    cfg_en = 1'b1;
    drain(FD * NB * 4 + 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Synthesizable UART transmitter that serialises bytes from a small FIFO onto a single TX line. The frame format is 8N1, or 8E1 when parity is compiled in. It is the SoC-side counterpart of the bench UART receiver/monitor. It sits behind the peripheral register interface: software pushes bytes through a valid/ready port, and `tx_o` drives the chip UART pin.

## Interface
- `DIV_WIDTH`, 16: width of the baud divisor.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of 2 and at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_en_i`  in  1  transmitter enable; when low, no new frame is started.
- `cfg_div_i`  in  DIV_WIDTH  bit period is `cfg_div_i+1` clock cycles.
- `tx_data_i`  in  8  byte to send.
- `tx_valid_i`  in  1  byte offered.
- `tx_ready_o`  out  1  FIFO not full; a byte is accepted when valid and ready are both high at an edge.
- `tx_o`  out  1  serial line; idles high.
- `busy_o`  out  1  a frame is in progress.
- `fifo_level_o`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.
- `tx_done_o`  out  1  one-cycle pulse in the last cycle of a STOP bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `tx_o`=1. If `cfg_en_i`=1 and FIFO level >0: pop the head entry into the shift register, latch `cfg_div_i` into the divisor register, then go to START.
- START: `tx_o`=0 for one bit period.
- DATA: 8 bits, LSB first. A 3-bit index counts 0..7; the shift register shifts right at the end of each bit.
- PARITY: `tx_o` = XOR of the 8 data bits (even parity), for one bit period.
- STOP: `tx_o`=1 for one bit period. In its last cycle, assert `tx_done_o` and then:
  - if `cfg_en_i`=1 and the FIFO is non-empty, pop and go directly to START (back-to-back frames with no idle gap);
  - otherwise go to IDLE.
- Bit timer: counts from the latched divisor down to 0; the bit ends when the count is 0. A divisor of 0 gives a 1-cycle bit.
- `cfg_div_i` changes take effect only at the next frame start. Deasserting `cfg_en_i` mid-frame lets the current frame finish.
- FIFO:
  - `tx_ready_o` = !full, combinational from the level.
  - A push and a pop in the same cycle leave the level unchanged.
  - A push while full cannot occur, because ready is low.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- `busy_o` = (state != IDLE).
- Reset values: `tx_o`=1, `busy_o`=0, `tx_done_o`=0, `tx_ready_o`=1, `fifo_level_o`=0, state=IDLE, FIFO pointers=0.
- Reset asserted mid-frame: `tx_o` returns high immediately (asynchronously) and the FIFO contents are discarded.

## Timing
- `tx_o` is driven from a flop; there are no combinational paths from inputs to `tx_o`.
- Latency: a byte accepted at edge N into an empty FIFO while IDLE → pop at edge N+1 → `tx_o` falls after edge N+1.
- Frame length: 10 × (div+1) cycles, or 11 × (div+1) with parity.
- `fifo_level_o` reflects pushes and pops one cycle after the accepting edge.
- Example: a 50 MHz clock with div=433 gives a 434-cycle bit = 8680 ns, which matches the bench at 115200 baud.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and frames are 8E1.
- Macro undefined: the PARITY state, the parity XOR and the related logic are absent, and STOP follows bit 7 directly (8N1).

## Structure
- `uart_pkg` holds:
  - the FSM state enum `uart_tx_state_e`;
  - localparams `UART_DATA_BITS`=8 and `UART_IDLE_LEVEL`=1'b1.
- The FIFO is a separate sub-module, `uart_tx_fifo` (parameterised depth and width, push/pop/full/empty/level).
- `uart_tx_core` contains the FSM, bit timer, shift register and parity logic.

## Test plan
- Single byte: div=9, send 0x55 → `tx_o` holds each bit for 10 cycles: 0,1,0,1,0,1,0,1,0,1; then `tx_done_o` pulses once and `busy_o` drops.
- Back-to-back: push 0x41, 0x42, 0x0A with div=433 at 50 MHz → the bench UART monitor prints "AB" with no idle gap between frames; the total is 30×434 cycles.
- FIFO full: with `cfg_en_i`=0, push 8 bytes → `tx_ready_o`=0 and level=8. Raise `cfg_en_i` → bytes are transmitted in FIFO order and ready returns high after the first pop.
- Parity (macro defined): send 0x07 → the parity bit is 1 and the bench reports no parity error. Send 0x03 → the parity bit is 0.
- Mid-frame events:
  - change `cfg_div_i` from 9 to 4 during bit 3 → the current frame keeps 10-cycle bits and the next frame uses 5-cycle bits;
  - assert `rst_n`=0 during DATA → `tx_o`=1 immediately and level=0.
- Divisor 0: div=0, send 0xF0 → 1-cycle bits: 0,0,0,0,0,1,1,1,1,1.
